vga_scaled_controller: RTL and testbench



---
 rtl/vga_scaled_controller.sv | 156 +++++++++++++++
 tb/tb_vga_scaled_controller.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scaled_controller.sv
// VGA raster controller: mode timing, 2^SCALE_LOG2 dot scaling, multiplier-free linear read addressing.
// Address 1 clock after the counters, DAC pins MEM_LATENCY+2 clocks after; free-running, no backpressure.
module vga_scaled_controller #(
    parameter int    H_ACTIVE                = 640,
    parameter int    H_FRONT                 = 16,
    parameter int    H_SYNC                  = 96,
    parameter int    H_BACK                  = 48,
    parameter int    V_ACTIVE                = 480,
    parameter int    V_FRONT                 = 10,
    parameter int    V_SYNC                  = 2,
    parameter int    V_BACK                  = 33,
    parameter bit    HS_POL                  = 1'b0,
    parameter bit    VS_POL                  = 1'b0,
    parameter int    SCALE_LOG2              = 1,
    parameter int    BITS_PER_COLOUR_CHANNEL = 1,
    parameter string MONOCHROME              = "FALSE",
    parameter int    MEM_LATENCY             = 1,
    parameter int    ADDR_WIDTH              = 17,
    localparam int   PC_W = (MONOCHROME == "TRUE") ? 1 : 3 * BITS_PER_COLOUR_CHANNEL
) (
    input  logic                  vga_clock,
    input  logic                  reset,
    input  logic [PC_W-1:0]       pixel_colour,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic [9:0]            VGA_R,
    output logic [9:0]            VGA_G,
    output logic [9:0]            VGA_B,
    output logic                  VGA_HS,
    output logic                  VGA_VS,
    output logic                  VGA_BLANK,
    output logic                  VGA_SYNC,
    output logic                  VGA_CLK,
    output logic                  frame_start,
    output logic                  vblank
);

    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int DOTS_X   = H_ACTIVE >> SCALE_LOG2;
    localparam int DOT_MASK = (1 << SCALE_LOG2) - 1;
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DEPTH    = MEM_LATENCY + 2;
    localparam int N        = BITS_PER_COLOUR_CHANNEL;
    localparam bit MONO     = (MONOCHROME == "TRUE");

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
        logic fs;
        logic vb;
    } ctl_t;

    // Sync stages reset to the idle level so no pulse appears while the pipe refills.
    localparam ctl_t CTL_RST = '{hs: ~HS_POL, vs: ~VS_POL, default: 1'b0};

    logic [HW-1:0]         h_q, h_d;
    logic [VW-1:0]         v_q, v_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    ctl_t                  ctl_d;
    ctl_t                  ctl_q [DEPTH];
    logic [9:0]            r_q, g_q, b_q;
    logic [9:0]            r_x, g_x, b_x;

    int   h_i, v_i;
    logic h_wrap, v_wrap, active, row_adv;

    assign h_i     = int'(h_q);
    assign v_i     = int'(v_q);
    assign h_wrap  = (h_i == H_TOTAL - 1);
    assign v_wrap  = (v_i == V_TOTAL - 1);
    assign active  = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
    // The row base steps only when the next line starts a new dot row.
    assign row_adv = ((v_i + 1) < V_ACTIVE) && (((v_i + 1) & DOT_MASK) == 0);

    always_comb begin
        h_d   = h_wrap ? '0 : h_q + HW'(1);
        v_d   = v_q;
        row_d = row_q;
        if (h_wrap) begin
            if (v_wrap) begin
                v_d   = '0;
                row_d = '0;
            end else begin
                v_d = v_q + VW'(1);
                if (row_adv) row_d = row_q + ADDR_WIDTH'(DOTS_X);
            end
        end
        addr_d      = active ? row_q + ADDR_WIDTH'(h_q >> SCALE_LOG2) : '0;
        ctl_d.hs    = ((h_i >= HS_START) && (h_i < HS_END)) ? HS_POL : ~HS_POL;
        ctl_d.vs    = ((v_i >= VS_START) && (v_i < VS_END)) ? VS_POL : ~VS_POL;
        ctl_d.blank = active;
        ctl_d.fs    = (h_i == 0) && (v_i == 0);
        ctl_d.vb    = (v_i >= V_ACTIVE);
    end

    function automatic logic [9:0] expand(input logic [N-1:0] val);
        logic [9:0] res;
        res = '0;
        for (int i = 0; i < 10; i++) res[9-i] = val[N-1-(i % N)];
        return res;
    endfunction

    if (MONO) begin : g_mono
        assign r_x = {10{pixel_colour[0]}};
        assign g_x = {10{pixel_colour[0]}};
        assign b_x = {10{pixel_colour[0]}};
    end else begin : g_rgb
        assign r_x = expand(pixel_colour[3*N-1 -: N]);
        assign g_x = expand(pixel_colour[2*N-1 -: N]);
        assign b_x = expand(pixel_colour[N-1 -: N]);
    end

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            h_q    <= '0;
            v_q    <= '0;
            row_q  <= '0;
            addr_q <= '0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            for (int i = 0; i < DEPTH; i++) ctl_q[i] <= CTL_RST;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            row_q    <= row_d;
            addr_q   <= addr_d;
            ctl_q[0] <= ctl_d;
            for (int i = 1; i < DEPTH; i++) ctl_q[i] <= ctl_q[i-1];
            // Stage MEM_LATENCY holds the position whose read data is on pixel_colour now.
            r_q <= ctl_q[MEM_LATENCY].blank ? r_x : '0;
            g_q <= ctl_q[MEM_LATENCY].blank ? g_x : '0;
            b_q <= ctl_q[MEM_LATENCY].blank ? b_x : '0;
        end
    end

    assign memory_address = addr_q;
    assign VGA_R          = r_q;
    assign VGA_G          = g_q;
    assign VGA_B          = b_q;
    assign VGA_HS         = ctl_q[DEPTH-1].hs;
    assign VGA_VS         = ctl_q[DEPTH-1].vs;
    assign VGA_BLANK      = ctl_q[DEPTH-1].blank;
    assign frame_start    = ctl_q[DEPTH-1].fs;
    assign vblank         = ctl_q[DEPTH-1].vb;
    assign VGA_SYNC       = 1'b1;
    assign VGA_CLK        = vga_clock;

endmodule

// File: tb/tb_vga_scaled_controller.sv
// Bench for vga_scaled_controller: default mode, scaled/wide colour, latency sweep, mono blanking, mid-frame reset.
module tb_vga_scaled_controller;

    localparam int SHA = 64, SHF = 4, SHS = 8, SHB = 4;
    localparam int SVA = 48, SVF = 2, SVS = 2, SVB = 3;
    localparam int SHT = SHA + SHF + SHS + SHB;
    localparam int SVT = SVA + SVF + SVS + SVB;

    logic clk = 1'b0;
    logic rst;
    int   cyc;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // Default-parameter instance
    logic [2:0]  pc_d;
    logic [16:0] addr_d;
    logic [9:0]  r_d, g_d, b_d;
    logic        hs_d, vs_d, bl_d, sync_d, vclk_d, fs_d, vb_d;
    vga_scaled_controller u_def (
        .vga_clock(clk), .reset(rst), .pixel_colour(pc_d), .memory_address(addr_d),
        .VGA_R(r_d), .VGA_G(g_d), .VGA_B(b_d), .VGA_HS(hs_d), .VGA_VS(vs_d),
        .VGA_BLANK(bl_d), .VGA_SYNC(sync_d), .VGA_CLK(vclk_d), .frame_start(fs_d), .vblank(vb_d));

    // 4x scaling, 3 bits per channel, full mode
    logic [8:0]  pc_c;
    logic [16:0] addr_c;
    logic [9:0]  r_c, g_c, b_c;
    logic        hs_c, vs_c, bl_c, sync_c, vclk_c, fs_c, vb_c;
    vga_scaled_controller #(.SCALE_LOG2(2), .BITS_PER_COLOUR_CHANNEL(3)) u_col (
        .vga_clock(clk), .reset(rst), .pixel_colour(pc_c), .memory_address(addr_c),
        .VGA_R(r_c), .VGA_G(g_c), .VGA_B(b_c), .VGA_HS(hs_c), .VGA_VS(vs_c),
        .VGA_BLANK(bl_c), .VGA_SYNC(sync_c), .VGA_CLK(vclk_c), .frame_start(fs_c), .vblank(vb_c));

    // Monochrome, positive syncs, 8x scaling, small mode
    logic        pc_m;
    logic [11:0] addr_m;
    logic [9:0]  r_m, g_m, b_m;
    logic        hs_m, vs_m, bl_m, sync_m, vclk_m, fs_m, vb_m;
    vga_scaled_controller #(
        .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .HS_POL(1'b1), .VS_POL(1'b1), .SCALE_LOG2(3), .MONOCHROME("TRUE"),
        .MEM_LATENCY(2), .ADDR_WIDTH(12)) u_mono (
        .vga_clock(clk), .reset(rst), .pixel_colour(pc_m), .memory_address(addr_m),
        .VGA_R(r_m), .VGA_G(g_m), .VGA_B(b_m), .VGA_HS(hs_m), .VGA_VS(vs_m),
        .VGA_BLANK(bl_m), .VGA_SYNC(sync_m), .VGA_CLK(vclk_m), .frame_start(fs_m), .vblank(vb_m));

    // Latency sweep: instance g has MEM_LATENCY=g, memory returns data = address
    logic [11:0] sw_addr [5];
    logic [11:0] sw_pc [5];
    logic [11:0] sw_mem [5][4];
    logic [9:0]  sw_r [5], sw_g [5], sw_b [5];
    logic        sw_hs [5], sw_vs [5], sw_bl [5], sw_sync [5], sw_vclk [5], sw_fs [5], sw_vb [5];

    always @(posedge clk) begin
        for (int g = 0; g < 5; g++) begin
            sw_mem[g][0] <= sw_addr[g];
            for (int k = 1; k < 4; k++) sw_mem[g][k] <= sw_mem[g][k-1];
        end
    end

    always_comb begin
        for (int g = 0; g < 5; g++) sw_pc[g] = (g == 0) ? sw_addr[g] : sw_mem[g][(g == 0) ? 0 : g - 1];
    end

    for (genvar g = 0; g < 5; g++) begin : g_sweep
        vga_scaled_controller #(
            .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
            .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
            .SCALE_LOG2(g % 3), .BITS_PER_COLOUR_CHANNEL(4), .MEM_LATENCY(g), .ADDR_WIDTH(12)) u_sw (
            .vga_clock(clk), .reset(rst), .pixel_colour(sw_pc[g]), .memory_address(sw_addr[g]),
            .VGA_R(sw_r[g]), .VGA_G(sw_g[g]), .VGA_B(sw_b[g]), .VGA_HS(sw_hs[g]), .VGA_VS(sw_vs[g]),
            .VGA_BLANK(sw_bl[g]), .VGA_SYNC(sw_sync[g]), .VGA_CLK(sw_vclk[g]),
            .frame_start(sw_fs[g]), .vblank(sw_vb[g]));
    end

    // Reference: what the raster should show at position index t (t<0 means pipeline refill)
    typedef struct packed {
        logic hs_a;
        logic vs_a;
        logic blank;
        logic fs;
        logic vb;
        int   addr;
    } ref_t;

    function automatic ref_t ref_at(input int t, input bit full, input int s);
        int   ha, hf, hsy, hbk, va, vf, vsy, vbk, ht, vt, h, v;
        ref_t r;
        r = '0;
        if (full) begin
            ha = 640; hf = 16; hsy = 96; hbk = 48; va = 480; vf = 10; vsy = 2; vbk = 33;
        end else begin
            ha = SHA; hf = SHF; hsy = SHS; hbk = SHB; va = SVA; vf = SVF; vsy = SVS; vbk = SVB;
        end
        if (t < 0) return r;
        ht = ha + hf + hsy + hbk;
        vt = va + vf + vsy + vbk;
        h = t % ht;
        v = (t / ht) % vt;
        r.hs_a  = (h >= ha + hf) && (h < ha + hf + hsy);
        r.vs_a  = (v >= va + vf) && (v < va + vf + vsy);
        r.blank = (h < ha) && (v < va);
        r.fs    = (h == 0) && (v == 0);
        r.vb    = (v >= va);
        r.addr  = r.blank ? (v >> s) * (ha >> s) + (h >> s) : 0;
        return r;
    endfunction

    // Repeat an n-bit value end to end and keep the first ten bits.
    function automatic logic [9:0] expand(input int val, input int n);
        logic [39:0] rep;
        rep = '0;
        for (int k = 0; k < 10; k++) rep = (rep << n) | 40'(val & ((1 << n) - 1));
        return 10'(rep >> (10 * n - 10));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic restart();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        checks++;
        if ({addr_d, r_d, g_d, b_d, hs_d, vs_d, bl_d, fs_d, vb_d, sync_d, vclk_d} !== {17'd0, 30'd0, 7'b1100011}) begin
            errors++;
            $display("FAIL reset_def: got %h %h%h%h %b%b%b%b%b%b%b", addr_d, r_d, g_d, b_d, hs_d, vs_d, bl_d, fs_d, vb_d, sync_d, vclk_d);
        end
        checks++;
        if ({addr_c, r_c, g_c, b_c, hs_c, vs_c, bl_c, fs_c, vb_c, sync_c, vclk_c} !== {17'd0, 30'd0, 7'b1100011}) begin
            errors++;
            $display("FAIL reset_col: got %h %b%b%b%b%b", addr_c, hs_c, vs_c, bl_c, fs_c, vb_c);
        end
        checks++;
        if ({addr_m, r_m, g_m, b_m, hs_m, vs_m, bl_m, fs_m, vb_m, sync_m, vclk_m} !== {12'd0, 30'd0, 7'b0000011}) begin
            errors++;
            $display("FAIL reset_mono: got %h %b%b%b%b%b want syncs 00", addr_m, hs_m, vs_m, bl_m, fs_m, vb_m);
        end
        for (int g = 0; g < 5; g++) begin
            checks++;
            if ({sw_addr[g], sw_r[g], sw_g[g], sw_b[g], sw_hs[g], sw_vs[g], sw_bl[g], sw_fs[g], sw_vb[g], sw_sync[g], sw_vclk[g]}
                !== {12'd0, 30'd0, 7'b1100011}) begin
                errors++;
                $display("FAIL reset_sweep%0d: got %h %b%b%b%b%b", g, sw_addr[g], sw_hs[g], sw_vs[g], sw_bl[g], sw_fs[g], sw_vb[g]);
            end
        end
    endtask

    task automatic test_defaults();
        ref_t o, a;
        int   first_fs, first_fall, low_cnt;
        logic prev_hs;
        first_fs = -1; first_fall = -1; low_cnt = 0; prev_hs = 1'b1;
        pc_d = 3'b111;
        restart();
        for (int n = 0; n < 3 * 800 + 3; n++) begin
            step();
            o = ref_at(cyc - 3, 1'b1, 1);
            a = ref_at(cyc - 1, 1'b1, 1);
            checks++;
            if ({hs_d, vs_d, bl_d, fs_d, vb_d} !== {~o.hs_a, ~o.vs_a, o.blank, o.fs, o.vb}) begin
                errors++;
                $display("FAIL def_ctl cyc=%0d: got %b%b%b%b%b want %b%b%b%b%b", cyc, hs_d, vs_d, bl_d, fs_d, vb_d,
                         ~o.hs_a, ~o.vs_a, o.blank, o.fs, o.vb);
            end
            checks++;
            if (addr_d !== 17'(a.addr)) begin
                errors++;
                $display("FAIL def_addr cyc=%0d: got %0d want %0d", cyc, addr_d, a.addr);
            end
            checks++;
            if ({r_d, g_d, b_d} !== (o.blank ? {30{1'b1}} : 30'd0)) begin
                errors++;
                $display("FAIL def_colour cyc=%0d: got %h want blank=%b", cyc, {r_d, g_d, b_d}, o.blank);
            end
            if (fs_d === 1'b1 && first_fs < 0) first_fs = cyc;
            if (hs_d === 1'b0 && prev_hs === 1'b1 && first_fall < 0) first_fall = cyc;
            if (hs_d === 1'b0 && cyc >= 3 && cyc < 803) low_cnt++;
            prev_hs = hs_d;
        end
        checks++;
        if (first_fs != 3) begin errors++; $display("FAIL def_frame_start: got cycle %0d want 3", first_fs); end
        checks++;
        if (first_fall != 659) begin errors++; $display("FAIL def_hs_fall: got cycle %0d want 659", first_fall); end
        checks++;
        if (low_cnt != 96) begin errors++; $display("FAIL def_hs_width: got %0d want 96", low_cnt); end
    endtask

    task automatic test_addressing();
        int t, h, v;
        restart();
        for (int n = 0; n < 2 * 800 + 2; n++) begin
            step();
            t = cyc - 1;
            h = t % 800;
            v = t / 800;
            if (h == 2 && v == 0) begin
                checks++;
                if (addr_d !== 17'd1) begin errors++; $display("FAIL addr_2_0: got %0d want 1", addr_d); end
            end
            if (h == 639 && v == 1) begin
                checks++;
                if (addr_d !== 17'd319) begin errors++; $display("FAIL addr_639_1: got %0d want 319", addr_d); end
            end
            if (h == 0 && v == 2) begin
                checks++;
                if (addr_d !== 17'd320) begin errors++; $display("FAIL addr_0_2: got %0d want 320", addr_d); end
            end
            if (h >= 640) begin
                checks++;
                if (addr_d !== 17'd0) begin errors++; $display("FAIL addr_hblank h=%0d: got %0d want 0", h, addr_d); end
            end
        end
    endtask

    task automatic test_scaling_colour();
        ref_t        o, a;
        logic [8:0]  held;
        logic [29:0] want;
        restart();
        for (int n = 0; n < 4 * 800 + 5; n++) begin
            pc_c = 9'($urandom);
            held = pc_c;
            step();
            o = ref_at(cyc - 3, 1'b1, 2);
            a = ref_at(cyc - 1, 1'b1, 2);
            want = o.blank ? {expand(int'(held[8:6]), 3), expand(int'(held[5:3]), 3), expand(int'(held[2:0]), 3)} : 30'd0;
            checks++;
            if ({r_c, g_c, b_c} !== want) begin
                errors++;
                $display("FAIL col_rand cyc=%0d: got %h want %h", cyc, {r_c, g_c, b_c}, want);
            end
            checks++;
            if (addr_c !== 17'(a.addr)) begin errors++; $display("FAIL col_addr cyc=%0d: got %0d want %0d", cyc, addr_c, a.addr); end
            if (cyc - 1 == 4 * 800 + 4) begin
                checks++;
                if (addr_c !== 17'd161) begin errors++; $display("FAIL col_addr_4_4: got %0d want 161", addr_c); end
            end
        end
        pc_c = 9'b101_000_111;
        step();
        checks++;
        if ({bl_c, r_c, g_c, b_c} !== {1'b1, 10'b1011011011, 10'd0, 10'h3FF}) begin
            errors++;
            $display("FAIL col_fixed: got blank=%b r=%b g=%b b=%b want 1 1011011011 0 3ff", bl_c, r_c, g_c, b_c);
        end
    endtask

    task automatic test_latency_sweep();
        ref_t        o, a;
        logic [29:0] want;
        restart();
        for (int n = 0; n < SHT * SVT + 12; n++) begin
            step();
            for (int g = 0; g < 5; g++) begin
                o = ref_at(cyc - 2 - g, 1'b0, g % 3);
                a = ref_at(cyc - 1, 1'b0, g % 3);
                want = o.blank ? {expand(o.addr >> 8, 4), expand(o.addr >> 4, 4), expand(o.addr, 4)} : 30'd0;
                checks++;
                if ({sw_r[g], sw_g[g], sw_b[g]} !== want) begin
                    errors++;
                    $display("FAIL sweep%0d_colour cyc=%0d: got %h want %h", g, cyc, {sw_r[g], sw_g[g], sw_b[g]}, want);
                end
                checks++;
                if ({sw_hs[g], sw_vs[g], sw_bl[g], sw_fs[g], sw_vb[g]} !== {~o.hs_a, ~o.vs_a, o.blank, o.fs, o.vb}) begin
                    errors++;
                    $display("FAIL sweep%0d_ctl cyc=%0d: got %b%b%b%b%b want %b%b%b%b%b", g, cyc, sw_hs[g], sw_vs[g],
                             sw_bl[g], sw_fs[g], sw_vb[g], ~o.hs_a, ~o.vs_a, o.blank, o.fs, o.vb);
                end
                checks++;
                if (sw_addr[g] !== 12'(a.addr)) begin
                    errors++;
                    $display("FAIL sweep%0d_addr cyc=%0d: got %0d want %0d", g, cyc, sw_addr[g], a.addr);
                end
            end
        end
    endtask

    task automatic test_blanking();
        ref_t o, a;
        pc_m = 1'b1;
        restart();
        for (int n = 0; n < SHT * SVT + 8; n++) begin
            step();
            o = ref_at(cyc - 4, 1'b0, 3);
            a = ref_at(cyc - 1, 1'b0, 3);
            checks++;
            if ({hs_m, vs_m, bl_m, fs_m, vb_m} !== {o.hs_a, o.vs_a, o.blank, o.fs, o.vb}) begin
                errors++;
                $display("FAIL blank_ctl cyc=%0d: got %b%b%b%b%b want %b%b%b%b%b", cyc, hs_m, vs_m, bl_m, fs_m, vb_m,
                         o.hs_a, o.vs_a, o.blank, o.fs, o.vb);
            end
            checks++;
            if ({r_m, g_m, b_m} !== (o.blank ? {30{1'b1}} : 30'd0)) begin
                errors++;
                $display("FAIL blank_colour cyc=%0d: got %h want blank=%b", cyc, {r_m, g_m, b_m}, o.blank);
            end
            checks++;
            if (addr_m !== 12'(a.addr)) begin errors++; $display("FAIL blank_addr cyc=%0d: got %0d want %0d", cyc, addr_m, a.addr); end
        end
    endtask

    task automatic test_reset_midframe();
        ref_t o;
        restart();
        while (cyc < 20 * SHT + 30) step();
        #1;
        rst = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            checks++;
            if ({sw_addr[g], sw_r[g], sw_g[g], sw_b[g], sw_hs[g], sw_vs[g], sw_bl[g], sw_fs[g], sw_vb[g]}
                !== {12'd0, 30'd0, 5'b11000}) begin
                errors++;
                $display("FAIL midreset%0d_immediate: got %h %h %b%b%b%b%b", g, sw_addr[g], {sw_r[g], sw_g[g], sw_b[g]},
                         sw_hs[g], sw_vs[g], sw_bl[g], sw_fs[g], sw_vb[g]);
            end
        end
        checks++;
        if ({addr_d, hs_d, vs_d, bl_d} !== {17'd0, 3'b110}) begin
            errors++;
            $display("FAIL midreset_def_immediate: got %h %b%b%b", addr_d, hs_d, vs_d, bl_d);
        end
        step(); step(); step();
        rst = 1'b0;
        cyc = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            for (int g = 0; g < 5; g++) begin
                o = ref_at(cyc - 2 - g, 1'b0, g % 3);
                checks++;
                if ({sw_fs[g], sw_hs[g], sw_vs[g], sw_bl[g]} !== {o.fs, ~o.hs_a, ~o.vs_a, o.blank}) begin
                    errors++;
                    $display("FAIL midreset%0d_restart cyc=%0d: got fs=%b hs=%b vs=%b bl=%b want fs=%b", g, cyc,
                             sw_fs[g], sw_hs[g], sw_vs[g], sw_bl[g], o.fs);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        pc_d = '0;
        pc_c = '0;
        pc_m = 1'b0;
        cyc = 0;
        step();
        step();
        test_reset();
        test_defaults();
        test_addressing();
        test_scaling_colour();
        test_latency_sweep();
        test_blanking();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
